// File: rtl/matrix_mult_param_if.sv
// Host-side bundle for matrix_mult_param: load/ack handshake, input matrix bus,
// registered result and status.
interface matrix_mult_param_if #(
  parameter int DIM = 4,
  parameter int W   = 16
);
  logic                 enable;
  logic                 RW;
  logic                 acc_mode;
  logic [DIM*DIM*W-1:0] dataInBus;
  logic [DIM*DIM*W-1:0] dataOut;
  logic                 fleg;
  logic                 busy;

  modport master (output enable, RW, acc_mode, dataInBus,
                  input  dataOut, fleg, busy);
  modport slave  (input  enable, RW, acc_mode, dataInBus,
                  output dataOut, fleg, busy);
endinterface

// File: rtl/matrix_mult_param.sv
// Square DIMxDIM unsigned matrix multiplier, one result element per cycle using
// DIM parallel multiplier lanes; optional accumulate onto the last result.
module mm_lane #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] p
);
  assign p = a * b;
endmodule

module matrix_mult_param #(
  parameter int DIM = 4,
  parameter int W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  matrix_mult_param_if.slave bus
);
  localparam int IW = (DIM > 1) ? $clog2(DIM) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIM - 1);

  // Packed so that element [i][j] sits at bits (i*DIM+j)*W +: W of the flat bus.
  typedef logic [DIM-1:0][DIM-1:0][W-1:0] mat_t;
  typedef enum logic [1:0] {IDLE, HAVE_A, COMPUTE, DONE} state_t;

  state_t               state, stateNext;
  mat_t                 matA, matB, resBuf, resOut, bufNext;
  logic                 accLat;
  logic [IW-1:0]        rowI, colJ;
  logic                 wr, loadA, loadB, lastElem;
  logic [DIM-1:0][W-1:0] prod;
  logic [W-1:0]         elem;
  logic                 fleg, busy;

  assign wr       = bus.enable & bus.RW;
  assign lastElem = (rowI == LAST) && (colJ == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    loadA     = 1'b0;
    loadB     = 1'b0;
    case (state)
      IDLE:    if (wr) begin loadA = 1'b1; stateNext = HAVE_A; end
      HAVE_A:  if (wr) begin loadB = 1'b1; stateNext = COMPUTE; end
      COMPUTE: if (lastElem) stateNext = DONE;
      DONE: if (bus.enable) begin
        loadA     = bus.RW;
        stateNext = bus.RW ? HAVE_A : IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  for (genvar k = 0; k < DIM; k++) begin : gLane
    mm_lane #(.W(W)) uLane (
      .a(matA[rowI][k]),
      .b(matB[k][colJ]),
      .p(prod[k])
    );
  end

  // Previous result for accumulate is the published dataOut, which only moves on DONE entry.
  always_comb begin
    elem = accLat ? resOut[rowI][colJ] : '0;
    for (int k = 0; k < DIM; k++) elem = elem + prod[k];
    bufNext             = resBuf;
    bufNext[rowI][colJ] = elem;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      matA   <= '0;
      matB   <= '0;
      resBuf <= '0;
      resOut <= '0;
      accLat <= 1'b0;
      rowI   <= '0;
      colJ   <= '0;
      fleg   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      fleg <= (stateNext == DONE);
      busy <= (stateNext == COMPUTE);
      if (loadA) matA <= bus.dataInBus;
      if (loadB) begin
        matB   <= bus.dataInBus;
        accLat <= bus.acc_mode;
        rowI   <= '0;
        colJ   <= '0;
      end
      if (state == COMPUTE) begin
        resBuf <= bufNext;
        if (colJ == LAST) begin
          colJ <= '0;
          rowI <= rowI + 1'b1;
        end else begin
          colJ <= colJ + 1'b1;
        end
        // Last element lands in the same edge that publishes the result.
        if (lastElem) resOut <= bufNext;
      end
    end
  end

  assign bus.dataOut = resOut;
  assign bus.fleg    = fleg;
  assign bus.busy    = busy;
endmodule

// File: tb/tb_matrix_mult_param.sv
// Directed bench for matrix_mult_param at DIM/W = 4/16, 2/8 and 8/32.
module tb_matrix_mult_param;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  matrix_mult_param_if #(.DIM(4), .W(16)) i4 ();
  matrix_mult_param_if #(.DIM(2), .W(8))  i2 ();
  matrix_mult_param_if #(.DIM(8), .W(32)) i8 ();

  matrix_mult_param #(.DIM(4), .W(16)) u4 (.clk(clk), .rst_n(rst_n), .bus(i4));
  matrix_mult_param #(.DIM(2), .W(8))  u2 (.clk(clk), .rst_n(rst_n), .bus(i2));
  matrix_mult_param #(.DIM(8), .W(32)) u8 (.clk(clk), .rst_n(rst_n), .bus(i8));

  typedef logic [3:0][3:0][15:0] m4_t;
  typedef logic [1:0][1:0][7:0]  m2_t;
  typedef logic [7:0][7:0][31:0] m8_t;

  int nVec = 0;
  int nBad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nVec++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ld4(input m4_t m, input logic acc);
    i4.enable = 1'b1; i4.RW = 1'b1; i4.dataInBus = m; i4.acc_mode = acc;
    tick();
    i4.enable = 1'b0; i4.RW = 1'b0;
  endtask

  task automatic ack4();
    i4.enable = 1'b1; i4.RW = 1'b0;
    tick();
    i4.enable = 1'b0;
  endtask

  task automatic wait4(input int start, output int n);
    n = start;
    do begin tick(); n++; end while (!i4.fleg && n < 200);
  endtask

  task automatic chkMat4(input string tag, input m4_t e);
    m4_t g;
    g = i4.dataOut;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        chk($sformatf("%s[%0d][%0d]", tag, i, j), 64'(g[i][j]), 64'(e[i][j]));
  endtask

  initial begin
    m4_t eye4, seq4, dbl4, ffff4, four4, rowA, colB, rc4, twos4, threes4, exp24;
    m2_t eye2, seq2, g2;
    m8_t eye8, seq8, g8;
    int n;

    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        eye4[i][j]    = (i == j) ? 16'd1 : 16'd0;
        seq4[i][j]    = 16'(i*4 + j + 1);
        dbl4[i][j]    = 16'(2*(i*4 + j + 1));
        ffff4[i][j]   = 16'hFFFF;
        four4[i][j]   = 16'h0004;
        rowA[i][j]    = 16'(i + 1);
        colB[i][j]    = 16'(j + 1);
        rc4[i][j]     = 16'(4*(i + 1)*(j + 1));
        twos4[i][j]   = 16'd2;
        threes4[i][j] = 16'd3;
        exp24[i][j]   = 16'd24;
      end
    seq2 = {8'd4, 8'd3, 8'd2, 8'd1};
    eye2 = {8'd1, 8'd0, 8'd0, 8'd1};
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        eye8[i][j] = (i == j) ? 32'd1 : 32'd0;
        seq8[i][j] = 32'h0100_0000 * (i + 1) + 32'(i*8 + j + 1);
      end

    i4.enable = 0; i4.RW = 0; i4.acc_mode = 0; i4.dataInBus = '0;
    i2.enable = 0; i2.RW = 0; i2.acc_mode = 0; i2.dataInBus = '0;
    i8.enable = 0; i8.RW = 0; i8.acc_mode = 0; i8.dataInBus = '0;

    #12;
    chk("rstFleg", 64'(i4.fleg), 64'd0);
    chk("rstBusy", 64'(i4.busy), 64'd0);
    chk("rstOut",  64'(|i4.dataOut), 64'd0);
    rst_n = 1'b1;
    tick();

    // identity x B, overwrite
    ld4(eye4, 1'b0);
    ld4(seq4, 1'b0);
    chk("busyT1", 64'(i4.busy), 64'd1);
    for (int t = 0; t < 8; t++) tick();
    chk("outHeldT1", 64'(|i4.dataOut), 64'd0);
    chk("flegMidT1", 64'(i4.fleg), 64'd0);
    wait4(8, n);
    chk("latT1", 64'(n), 64'd16);
    chk("busyDoneT1", 64'(i4.busy), 64'd0);
    chkMat4("idB", seq4);
    ack4();
    chk("flegAck", 64'(i4.fleg), 64'd0);

    // same again, accumulating
    ld4(eye4, 1'b0);
    ld4(seq4, 1'b1);
    wait4(0, n);
    chk("latAcc", 64'(n), 64'd16);
    chkMat4("acc", dbl4);
    ack4();

    // modulo wrap
    ld4(ffff4, 1'b0);
    ld4(ffff4, 1'b0);
    wait4(0, n);
    chkMat4("wrap", four4);
    ack4();

    // row/column orientation
    ld4(rowA, 1'b0);
    ld4(colB, 1'b0);
    wait4(0, n);
    chkMat4("rc", rc4);
    ack4();

    // async reset at idx 7 of COMPUTE
    ld4(eye4, 1'b0);
    ld4(ffff4, 1'b0);
    for (int t = 0; t < 7; t++) tick();
    rst_n = 1'b0;
    #1;
    chk("midRstFleg", 64'(i4.fleg), 64'd0);
    chk("midRstBusy", 64'(i4.busy), 64'd0);
    chk("midRstOut",  64'(|i4.dataOut), 64'd0);
    #2;
    rst_n = 1'b1;
    tick();
    chk("postRstOut", 64'(|i4.dataOut), 64'd0);
    ld4(eye4, 1'b0);
    ld4(seq4, 1'b0);
    wait4(0, n);
    chk("latPostRst", 64'(n), 64'd16);
    chkMat4("postRst", seq4);
    ack4();

    // bus activity during COMPUTE is ignored
    ld4(eye4, 1'b0);
    ld4(seq4, 1'b0);
    n = 0;
    while (!i4.fleg && n < 200) begin
      i4.enable = 1'b1; i4.RW = n[0]; i4.acc_mode = 1'b1; i4.dataInBus = ffff4;
      tick();
      n++;
    end
    i4.enable = 1'b0; i4.RW = 1'b0; i4.acc_mode = 1'b0;
    chk("latNoise", 64'(n), 64'd16);
    chkMat4("noise", seq4);
    // implicit acknowledge: load in DONE goes straight to HAVE_A
    ld4(twos4, 1'b0);
    chk("implAckFleg", 64'(i4.fleg), 64'd0);
    chk("implAckOut", 64'(i4.dataOut), 64'(seq4));
    ld4(threes4, 1'b0);
    chk("implAckBusy", 64'(i4.busy), 64'd1);
    wait4(0, n);
    chk("latImpl", 64'(n), 64'd16);
    chkMat4("implAck", exp24);
    ack4();

    // DIM=2, W=8
    i2.enable = 1; i2.RW = 1; i2.dataInBus = eye2; tick();
    i2.dataInBus = seq2; tick();
    i2.enable = 0; i2.RW = 0;
    n = 0;
    do begin tick(); n++; end while (!i2.fleg && n < 100);
    chk("lat2", 64'(n), 64'd4);
    g2 = i2.dataOut;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        chk($sformatf("d2[%0d][%0d]", i, j), 64'(g2[i][j]), 64'(i*2 + j + 1));

    // DIM=8, W=32
    i8.enable = 1; i8.RW = 1; i8.dataInBus = eye8; tick();
    i8.dataInBus = seq8; tick();
    i8.enable = 0; i8.RW = 0;
    n = 0;
    do begin tick(); n++; end while (!i8.fleg && n < 300);
    chk("lat8", 64'(n), 64'd64);
    g8 = i8.dataOut;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        chk($sformatf("d8[%0d][%0d]", i, j), 64'(g8[i][j]),
            64'(32'h0100_0000 * (i + 1) + 32'(i*8 + j + 1)));

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end
endmodule
